// File: rtl/sprite_fetch.sv
// sprite_fetch: reads N sprite bytes from memory for a DXYN draw,
// packs them and drives a two-cycle draw strobe to the display stage.
// Ports: clk, rst_n | start, addr_i, vx, vy, n (CPU request)
//        mem_rd, mem_addr, mem_data (shared memory read port)
//        sprite_data, height, row, col, draw (to display stage)
//        busy, done (CPU stall / completion)
module sprite_fetch #(
  parameter int ADDR_W   = 12,
  parameter int MAX_ROWS = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [7:0]            vx,
  input  logic [7:0]            vy,
  input  logic [3:0]            n,
  output logic                  mem_rd,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [7:0]            mem_data,
  output logic [MAX_ROWS*8-1:0] sprite_data,
  output logic [7:0]            height,
  output logic [7:0]            row,
  output logic [7:0]            col,
  output logic                  draw,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LAST, DRAW0, DRAW1, DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [3:0]            k_q, k_d;
  logic [MAX_ROWS*8-1:0] spr_q, spr_d;
  logic [7:0]            height_q, height_d;
  logic [7:0]            row_q, row_d;
  logic [7:0]            col_q, col_d;
  logic                  cap_en;
  logic [3:0]            cap_idx;

  // Coordinates wrap to the 64x32 screen; upper bits are dropped.
  logic unused_ok;
  assign unused_ok = ^{vx[7:6], vy[7:5]};

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    k_d      = k_q;
    spr_d    = spr_q;
    height_d = height_q;
    row_d    = row_q;
    col_d    = col_q;
    cap_en   = 1'b0;
    cap_idx  = 4'd0;
    mem_rd   = 1'b0;
    mem_addr = '0;
    draw     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d   = addr_i;
          height_d = {4'd0, n};
          row_d    = {3'd0, vy[4:0]};
          col_d    = {2'd0, vx[5:0]};
          spr_d    = '0;
          k_d      = 4'd0;
          state_d  = (n == 4'd0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = base_q + ADDR_W'(k_q);
        // Data for the read issued last cycle arrives now.
        cap_en   = (k_q != 4'd0);
        cap_idx  = k_q - 4'd1;
        if (k_q == height_q[3:0] - 4'd1) begin
          state_d = LAST;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      LAST: begin
        cap_en  = 1'b1;
        cap_idx = k_q;
        state_d = DRAW0;
      end
      DRAW0: begin
        draw    = 1'b1;
        state_d = DRAW1;
      end
      DRAW1: begin
        draw    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Row 0 sits in the top byte of the bus.
    for (int i = 0; i < MAX_ROWS; i++) begin
      if (cap_en && cap_idx == 4'(i)) begin
        spr_d[(MAX_ROWS-1-i)*8 +: 8] = mem_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      k_q      <= 4'd0;
      spr_q    <= '0;
      height_q <= 8'd0;
      row_q    <= 8'd0;
      col_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      k_q      <= k_d;
      spr_q    <= spr_d;
      height_q <= height_d;
      row_q    <= row_d;
      col_q    <= col_d;
    end
  end

  assign sprite_data = spr_q;
  assign height      = height_q;
  assign row         = row_q;
  assign col         = col_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_sprite_fetch.sv
// tb_sprite_fetch: scoreboard bench for sprite_fetch.
// Memory model answers one cycle after mem_rd.
module tb_sprite_fetch;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [11:0]  addr_i = '0;
  logic [7:0]   vx = '0;
  logic [7:0]   vy = '0;
  logic [3:0]   n = '0;
  logic         mem_rd;
  logic [11:0]  mem_addr;
  logic [7:0]   mem_data = '0;
  logic [119:0] sprite_data;
  logic [7:0]   height, row, col;
  logic         draw, busy, done;

  sprite_fetch #(.ADDR_W(12), .MAX_ROWS(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .addr_i(addr_i), .vx(vx), .vy(vy), .n(n),
    .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data),
    .sprite_data(sprite_data), .height(height),
    .row(row), .col(col), .draw(draw),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [4096];

  always @(posedge clk)
    mem_data <= mem_rd ? mem[mem_addr] : 8'($urandom);

  typedef struct {
    logic [119:0] spr;
    logic [7:0]   h;
    logic [7:0]   r;
    logic [7:0]   c;
  } res_t;

  res_t        res_q[$];
  logic [11:0] addr_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0 = 0;
  int rd_cnt, first_rd, last_rd;
  int draw_first, draw_cnt;
  int done_rel, done_cnt, busy_cnt;

  task automatic check(string tag, logic [127:0] got,
                       logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      int rel;
      res_t r;
      rel = cyc - t0 + 1;
      if (mem_rd) begin
        rd_cnt++;
        if (first_rd == 0) first_rd = rel;
        last_rd = rel;
        if (addr_q.size() == 0)
          check("rd_unexp", mem_rd, 1'b0);
        else
          check("mem_addr", mem_addr, addr_q.pop_front());
      end
      if (draw) begin
        if (draw_cnt == 0) begin
          draw_first = rel;
          if (res_q.size() == 0) begin
            check("draw_unexp", draw, 1'b0);
          end else begin
            r = res_q.pop_front();
            check("sprite", sprite_data, r.spr);
            check("height", height, r.h);
            check("row", row, r.r);
            check("col", col, r.c);
          end
        end
        draw_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_rel = rel;
      end
      if (busy) busy_cnt++;
    end
  end

  task automatic clr_mon();
    rd_cnt = 0; first_rd = 0; last_rd = 0;
    draw_first = 0; draw_cnt = 0;
    done_rel = 0; done_cnt = 0; busy_cnt = 0;
  endtask

  task automatic launch(logic [11:0] a, int nn,
                        logic [7:0] x, logic [7:0] y);
    @(negedge clk);
    addr_i = a; n = 4'(nn); vx = x; vy = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic run_draw(logic [11:0] a, int nn,
                          logic [7:0] x, logic [7:0] y,
                          bit poke);
    res_t e;
    logic [11:0] ad;
    bit fin;
    e.spr = '0;
    for (int j = 0; j < nn; j++) begin
      ad = a + 12'(j);
      addr_q.push_back(ad);
      e.spr[(14-j)*8 +: 8] = mem[ad];
    end
    e.h = 8'(nn);
    e.r = 8'(y % 32);
    e.c = 8'(x % 64);
    if (nn > 0) res_q.push_back(e);
    clr_mon();
    launch(a, nn, x, y);
    fin = 0;
    for (int i = 0; i < 40 && !fin; i++) begin
      @(negedge clk);
      #1;
      start = 1'b0;
      if (poke && (cyc - t0 + 1) == 3) begin
        addr_i = 12'h000; n = 4'd2;
        vx = 8'h3F; vy = 8'h1F;
        start = 1'b1;
      end
      if (done_cnt > 0) fin = 1;
    end
    start = 1'b0;
    if (!fin) check("timeout", done_cnt, 1);
    repeat (2) @(negedge clk);
    #1;
    check("rd_cnt", rd_cnt, nn);
    if (nn > 0) begin
      check("first_rd", first_rd, 1);
      check("last_rd", last_rd, nn);
      check("draw_first", draw_first, nn + 2);
      check("draw_cnt", draw_cnt, 2);
      check("done_rel", done_rel, nn + 4);
      check("busy_cnt", busy_cnt, nn + 4);
    end else begin
      check("draw_cnt0", draw_cnt, 0);
      check("done_rel0", done_rel, 1);
      check("busy_cnt0", busy_cnt, 1);
    end
    check("done_cnt", done_cnt, 1);
    check("busy_idle", busy, 1'b0);
    check("addr_left", addr_q.size(), 0);
    check("res_left", res_q.size(), 0);
  endtask

  task automatic chk_zero(string tag);
    check({tag, "_rd"}, mem_rd, 1'b0);
    check({tag, "_addr"}, mem_addr, 12'h000);
    check({tag, "_spr"}, sprite_data, 120'h0);
    check({tag, "_hrc"}, {height, row, col}, 24'h0);
    check({tag, "_ctl"}, {draw, busy, done}, 3'b000);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[12'h050] = 8'hF0; mem[12'h051] = 8'h90;
    mem[12'h052] = 8'h90; mem[12'h053] = 8'h90;
    mem[12'h054] = 8'hF0;
    for (int i = 0; i < 15; i++) mem[12'h100 + 12'(i)] = 8'hFF;
    mem[12'h120] = 8'h81;
    clr_mon();

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Font digit 0
    run_draw(12'h050, 5, 8'h0A, 8'h03, 0);
    check("font_top", sprite_data[119:80], 40'hF0909090F0);
    check("font_rest", sprite_data[79:0], 80'h0);
    // Coordinate wrap
    run_draw(12'h300, 4, 8'd70, 8'd40, 0);
    check("col_wrap", col, 8'd6);
    check("row_wrap", row, 8'd8);
    // Address wrap
    run_draw(12'hFFE, 3, 8'h10, 8'h05, 0);
    // Zero-height sprite
    run_draw(12'h400, 0, 8'h01, 8'h02, 0);
    // Tall sprite with an ignored start, then short one
    run_draw(12'h100, 15, 8'h20, 8'h10, 1);
    run_draw(12'h120, 1, 8'h05, 8'h06, 0);
    check("short_spr", sprite_data, {8'h81, 112'h0});
    // Random heights
    for (int t = 0; t < 4; t++)
      run_draw(12'($urandom), int'($urandom_range(1, 15)),
               8'($urandom), 8'($urandom), 0);

    // Reset in cycle 3 of an 8-byte fetch
    clr_mon();
    for (int j = 0; j < 3; j++) addr_q.push_back(12'h200 + 12'(j));
    launch(12'h200, 8, 8'h11, 8'h22);
    for (int i = 0; i < 10 && (cyc - t0 + 1) < 3; i++)
      @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    check("midrst_rds", rd_cnt, 3);
    check("midrst_q", addr_q.size(), 0);
    addr_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_draw(12'h050, 5, 8'h3F, 8'h1F, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_fetch.md
Name: sprite_fetch

Overview:
- Upstream feeder for the display stage. On a DXYN draw request it reads N sprite bytes from main memory starting at I, packs them into the 120-bit sprite bus, and latches the wrapped draw coordinates.
- It then holds the display stage's draw line high for exactly two cycles. The display stage needs one cycle to compute collision and one to XOR the sprite into VRAM.
- Sits between the CPU execute unit and the display stage; shares the memory read port with the CPU, which stalls while busy is high.

Parameters:
- ADDR_W, 12, memory address width (CHIP-8 4 KiB space).
- MAX_ROWS, 15, maximum sprite height in bytes; sprite bus width is MAX_ROWS*8.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle draw request from CPU; sampled only in IDLE.
- addr_i  in  ADDR_W  sprite base address (I register).
- vx  in  8  raw Vx value.
- vy  in  8  raw Vy value.
- n  in  4  sprite height in bytes.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory read address.
- mem_data  in  8  read data, valid exactly one cycle after mem_rd.
- sprite_data  out  120  packed sprite; row 0 in bits 119:112.
- height  out  8  latched n, zero-extended.
- row  out  8  latched vy mod 32.
- col  out  8  latched vx mod 64.
- draw  out  1  draw strobe to display stage.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All outputs and registers go to 0: sprite_data, height, row, col, mem_rd, mem_addr, draw, busy, done.
- States: IDLE, FETCH, LAST, DRAW0, DRAW1, DONE.
- IDLE:
  - On start=1 at edge T0, latch the following, then go to FETCH (n≥1) or DONE (n=0):
    - addr_i into a base register.
    - n into height.
    - vy[4:0] into row (upper bits 0).
    - vx[5:0] into col (upper bits 0).
    - Clear sprite_data to 0 and the byte counter k to 0.
- FETCH:
  - Each cycle: mem_rd=1, mem_addr=(base+k) truncated to ADDR_W, so 0xFFF+1 wraps to 0x000.
  - Byte k-1 from the previous read is captured at the same edge.
  - Byte j is stored at sprite_data[(14-j)*8+7 : (14-j)*8].
  - After issuing read k=n-1, go to LAST.
- LAST: mem_rd=0; capture byte n-1; go to DRAW0.
- DRAW0, DRAW1: draw=1; sprite_data, row, col and height are held stable.
- DONE: done=1 for one cycle; return to IDLE.
- Latency with start at edge T0 and n≥1:
  - mem_rd high in cycles 1..n.
  - draw high in cycles n+2 and n+3.
  - done in cycle n+4.
  - busy high in cycles 1..n+4.
- n=0: no memory reads, draw never asserted, done in cycle 1, busy in cycle 1 only.
- start while busy is ignored; no queueing. start and reset together: reset wins.
- Bytes beyond n are always 0, so stale bytes from a prior taller sprite never leak through.
- draw is never asserted for other than exactly 2 consecutive cycles.
- Reset during DRAW0 or DRAW1 drops draw immediately. The display stage must be reset by the same rst_n, because its two-cycle sequencing is otherwise left mid-sequence.
- mem_data is ignored outside capture cycles.

Test Plan:
1. Font digit "0": memory 0x050..0x054 = F0 90 90 90 F0, addr_i=0x050, n=5, vx=0x0A, vy=0x03, start at T0:
   - mem_addr = 0x050..0x054 in cycles 1-5.
   - sprite_data[119:80]=F0909090F0, rest 0.
   - draw high cycles 7-8, done cycle 9, row=3, col=10, height=5.
2. Coordinate wrap: vx=70, vy=40 → col=6, row=8.
3. Address wrap: addr_i=0xFFE, n=3 → mem_addr sequence 0xFFE, 0xFFF, 0x000.
4. n=0 → mem_rd never high, draw never high, done and busy high in cycle 1 only.
5. Back-to-back: n=15 of all 0xFF, then n=1 with byte 0x81 → second sprite_data = 0x81 followed by 112 zero bits. start pulsed during the first fetch is ignored.
6. Reset mid-FETCH (cycle 3 of n=8) → all outputs 0 immediately, state IDLE; a subsequent start completes normally.
